// File: rtl/wb_merge_pkg.sv
// Shared widths and the writeback packet used by the load queue and the
// register-file write port.
package wb_merge_pkg;
  localparam int DATA_W         = 16;
  localparam int IDX_W          = 6;
  localparam int PHY_W          = 6;
  localparam int WB_DEPTH       = 4;
  localparam int WB_STARVE_MAX  = 3;

  typedef struct packed {
    logic              reg_wrt;
    logic [IDX_W-1:0]  indx;
    logic [PHY_W-1:0]  phy_addr;
    logic [DATA_W-1:0] data;
  } wb_pkt_t;
endpackage

// File: rtl/wb_merge_if.sv
// Load, ALU and writeback signal bundle for the writeback merge stage.
interface wb_merge_if #(parameter int DEPTH = wb_merge_pkg::WB_DEPTH);
  import wb_merge_pkg::*;

  logic              flsh;
  logic              vld_ld;
  logic              reg_wrt_ld;
  logic [IDX_W-1:0]  indx_ld;
  logic [PHY_W-1:0]  phy_addr_ld;
  logic [DATA_W-1:0] data_ld;
  logic              alu_vld;
  logic              alu_reg_wrt;
  logic [IDX_W-1:0]  alu_indx;
  logic [PHY_W-1:0]  alu_phy_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stll;
  logic              wb_vld;
  logic              wb_reg_wrt;
  logic [IDX_W-1:0]  wb_indx;
  logic [PHY_W-1:0]  wb_phy_addr;
  logic [DATA_W-1:0] wb_data;
  logic [$clog2(DEPTH):0] fifo_cnt;

  // master: the pipeline feeding results; slave: the merge stage
  modport master (
    output flsh, vld_ld, reg_wrt_ld, indx_ld, phy_addr_ld, data_ld,
           alu_vld, alu_reg_wrt, alu_indx, alu_phy_addr, alu_data,
    input  alu_stll, wb_vld, wb_reg_wrt, wb_indx, wb_phy_addr, wb_data, fifo_cnt
  );
  modport slave (
    input  flsh, vld_ld, reg_wrt_ld, indx_ld, phy_addr_ld, data_ld,
           alu_vld, alu_reg_wrt, alu_indx, alu_phy_addr, alu_data,
    output alu_stll, wb_vld, wb_reg_wrt, wb_indx, wb_phy_addr, wb_data, fifo_cnt
  );
endinterface

// File: rtl/wb_merge_ld_fifo.sv
// In-order load-result queue with same-cycle push and pop; clr empties it.
module wb_ld_fifo
  import wb_merge_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  wb_pkt_t       din,
  output wb_pkt_t       head,
  output logic [AW:0]   cnt
);
  wb_pkt_t           r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wr <= r_wr + 1'b1;
      if (pop)  r_rd <= r_rd + 1'b1;
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr && push) r_mem[r_wr] <= din;
  end

  assign head = r_mem[r_rd];
  assign cnt  = r_cnt;

  // Arbitration must drain before the queue can ever fill completely
  a_no_overflow: assert property (@(posedge clk) disable iff (rst || clr)
    !(push && (r_cnt == (AW+1)'(DEPTH))));
endmodule

// File: rtl/wb_merge.sv
// Writeback merge: arbitrates buffered/bypassed load results against the ALU
// into one registered writeback port, with bounded ALU starvation.
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter int DEPTH      = WB_DEPTH,
  parameter int STARVE_MAX = WB_STARVE_MAX,
  localparam int AW        = $clog2(DEPTH),
  localparam int SW        = $clog2(STARVE_MAX + 1)
) (
  input  logic     clk,
  input  logic     rst,
  wb_merge_if.slave bus
);
  localparam logic [AW:0]   CNT_HI     = (AW+1)'(DEPTH - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  wb_pkt_t       w_ld_pkt;
  wb_pkt_t       w_alu_pkt;
  wb_pkt_t       w_head;
  logic [AW:0]   w_cnt;
  logic          w_empty;
  logic          w_ld_pend;
  logic          w_ld_gnt;
  logic          w_alu_gnt;
  logic          w_push;
  logic          w_pop;

  logic [SW-1:0] r_starve;
  logic          r_wb_vld;
  wb_pkt_t       r_wb_pkt;

  assign w_ld_pkt  = '{reg_wrt: bus.reg_wrt_ld, indx: bus.indx_ld,
                       phy_addr: bus.phy_addr_ld, data: bus.data_ld};
  assign w_alu_pkt = '{reg_wrt: bus.alu_reg_wrt, indx: bus.alu_indx,
                       phy_addr: bus.alu_phy_addr, data: bus.alu_data};

  assign w_empty   = (w_cnt == '0);
  assign w_ld_pend = !w_empty || bus.vld_ld;
  assign w_ld_gnt  = w_ld_pend &&
                     (!bus.alu_vld || (r_starve == STARVE_TOP) || (w_cnt >= CNT_HI));
  assign w_alu_gnt = bus.alu_vld && !w_ld_gnt;

  // An incoming load bypasses only when granted with nothing queued ahead of it
  assign w_pop  = w_ld_gnt && !w_empty && !bus.flsh;
  assign w_push = bus.vld_ld && !bus.flsh && !(w_ld_gnt && w_empty);

  assign bus.alu_stll = bus.alu_vld && w_ld_gnt && !rst && !bus.flsh;

  wb_ld_fifo #(.DEPTH(DEPTH)) u_ld_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.flsh),
    .push (w_push),
    .pop  (w_pop),
    .din  (w_ld_pkt),
    .head (w_head),
    .cnt  (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.flsh) begin
      r_starve <= '0;
    end else if (w_ld_gnt || !w_ld_pend) begin
      r_starve <= '0;
    end else if (w_alu_gnt && (r_starve != STARVE_TOP)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_vld <= 1'b0;
      r_wb_pkt <= '0;
    end else if (bus.flsh) begin
      r_wb_vld <= 1'b0;
    end else if (w_ld_gnt) begin
      r_wb_vld <= 1'b1;
      r_wb_pkt <= w_empty ? w_ld_pkt : w_head;
    end else if (w_alu_gnt) begin
      r_wb_vld <= 1'b1;
      r_wb_pkt <= w_alu_pkt;
    end else begin
      r_wb_vld <= 1'b0;
    end
  end

  assign bus.wb_vld      = r_wb_vld;
  assign bus.wb_reg_wrt  = r_wb_pkt.reg_wrt;
  assign bus.wb_indx     = r_wb_pkt.indx;
  assign bus.wb_phy_addr = r_wb_pkt.phy_addr;
  assign bus.wb_data     = r_wb_pkt.data;
  // fifo_cnt is reset with the queue, so it reads 0 while rst is held
  assign bus.fifo_cnt    = w_cnt;
endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge: bypass, collision, starvation, pressure,
// flush and reset scenarios with hand-computed expectations.
module tb_wb_merge;
  import wb_merge_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wb_merge_if #(.DEPTH(4)) bus ();

  wb_merge #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_ld(input logic v, input logic rw, input logic [5:0] idx,
                        input logic [5:0] phy, input logic [15:0] d);
    bus.vld_ld = v; bus.reg_wrt_ld = rw; bus.indx_ld = idx;
    bus.phy_addr_ld = phy; bus.data_ld = d;
  endtask

  task automatic drv_alu(input logic v, input logic [5:0] idx, input logic [15:0] d);
    bus.alu_vld = v; bus.alu_reg_wrt = 1'b1; bus.alu_indx = idx;
    bus.alu_phy_addr = 6'd1; bus.alu_data = d;
  endtask

  logic [15:0] ldq[$];
  int          max_cnt;

  initial begin
    bus.flsh = 1'b0;
    drv_ld(1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    drv_alu(1'b0, 6'd0, 16'h0);

    // Reset state
    tick(); tick();
    chk("rst_wb_vld", bus.wb_vld, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_wb_indx", bus.wb_indx, 0);
    chk("rst_fifo_cnt", bus.fifo_cnt, 0);
    chk("rst_stll", bus.alu_stll, 0);
    rst = 1'b0;
    tick();

    // 1. Lone load bypasses
    drv_ld(1'b1, 1'b1, 6'd5, 6'd12, 16'hBEEF);
    tick();
    drv_ld(1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    chk("lone_vld", bus.wb_vld, 1);
    chk("lone_indx", bus.wb_indx, 5);
    chk("lone_phy", bus.wb_phy_addr, 12);
    chk("lone_data", bus.wb_data, 16'hBEEF);
    chk("lone_rw", bus.wb_reg_wrt, 1);
    chk("lone_cnt", bus.fifo_cnt, 0);
    tick();
    chk("lone_idle_vld", bus.wb_vld, 0);
    chk("lone_idle_hold", bus.wb_data, 16'hBEEF);

    // 2. Collision; load has reg_wrt=0
    drv_alu(1'b1, 6'd1, 16'h1111);
    drv_ld(1'b1, 1'b0, 6'd2, 6'd4, 16'h2222);
    #1 chk("col_stll0", bus.alu_stll, 0);
    tick();
    drv_alu(1'b0, 6'd0, 16'h0);
    drv_ld(1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    chk("col_alu_data", bus.wb_data, 16'h1111);
    chk("col_cnt1", bus.fifo_cnt, 1);
    #1 chk("col_stll1", bus.alu_stll, 0);
    tick();
    chk("col_ld_vld", bus.wb_vld, 1);
    chk("col_ld_data", bus.wb_data, 16'h2222);
    chk("col_ld_rw", bus.wb_reg_wrt, 0);
    chk("col_ld_indx", bus.wb_indx, 2);
    chk("col_cnt0", bus.fifo_cnt, 0);
    tick();

    // 3. Starvation: ALU result advances only when not stalled
    drv_alu(1'b1, 6'd10, 16'h0A00);
    drv_ld(1'b1, 1'b1, 6'd7, 6'd7, 16'h3333);
    #1 chk("stv_stll_t0", bus.alu_stll, 0);
    tick();
    drv_ld(1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    chk("stv_t1_data", bus.wb_data, 16'h0A00);
    chk("stv_t1_cnt", bus.fifo_cnt, 1);
    drv_alu(1'b1, 6'd11, 16'h0A01);
    #1 chk("stv_stll_t1", bus.alu_stll, 0);
    tick();
    chk("stv_t2_data", bus.wb_data, 16'h0A01);
    drv_alu(1'b1, 6'd12, 16'h0A02);
    #1 chk("stv_stll_t2", bus.alu_stll, 0);
    tick();
    chk("stv_t3_data", bus.wb_data, 16'h0A02);
    drv_alu(1'b1, 6'd13, 16'h0A03);
    #1 chk("stv_stll_t3", bus.alu_stll, 1);
    tick();
    chk("stv_t4_ld", bus.wb_data, 16'h3333);
    chk("stv_t4_indx", bus.wb_indx, 7);
    chk("stv_t4_cnt", bus.fifo_cnt, 0);
    #1 chk("stv_stll_t4", bus.alu_stll, 0);
    tick();
    chk("stv_t5_alu", bus.wb_data, 16'h0A03);
    chk("stv_t5_indx", bus.wb_indx, 13);
    drv_alu(1'b1, 6'd14, 16'h0A04); tick();
    drv_alu(1'b1, 6'd15, 16'h0A05); tick();
    drv_alu(1'b1, 6'd16, 16'h0A06); tick();
    chk("stv_tail", bus.wb_data, 16'h0A06);
    drv_alu(1'b0, 6'd0, 16'h0);
    tick();

    // 4. Pressure: ALU always valid, six back-to-back loads
    max_cnt = 0;
    ldq.delete();
    drv_alu(1'b1, 6'h3F, 16'h5555);
    for (int i = 0; i < 24; i++) begin
      if (i < 6) drv_ld(1'b1, 1'b1, 6'(6'h20 + i), 6'd2, 16'(16'hA0 + i));
      else       drv_ld(1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
      if (i == 20) drv_alu(1'b0, 6'd0, 16'h0);
      tick();
      if (int'(bus.fifo_cnt) > max_cnt) max_cnt = int'(bus.fifo_cnt);
      if (bus.wb_vld && bus.wb_indx != 6'h3F) ldq.push_back(bus.wb_data);
    end
    chk("prs_max_cnt", max_cnt, 3);
    chk("prs_nloads", ldq.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("prs_order", (i < ldq.size()) ? {16'h0, ldq[i]} : 32'hDEAD, 32'(16'hA0 + i));
    chk("prs_drained", bus.fifo_cnt, 0);

    // 5. Flush with two queued loads plus a new load and an ALU result
    drv_alu(1'b1, 6'h30, 16'h6666);
    drv_ld(1'b1, 1'b1, 6'h31, 6'd3, 16'h00F1); tick();
    drv_ld(1'b1, 1'b1, 6'h32, 6'd3, 16'h00F2); tick();
    chk("fl_pre_cnt", bus.fifo_cnt, 2);
    bus.flsh = 1'b1;
    drv_alu(1'b1, 6'h33, 16'h7777);
    drv_ld(1'b1, 1'b1, 6'h34, 6'd3, 16'h00F3);
    #1 chk("fl_stll", bus.alu_stll, 0);
    tick();
    bus.flsh = 1'b0;
    drv_alu(1'b0, 6'd0, 16'h0);
    drv_ld(1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    chk("fl_vld", bus.wb_vld, 0);
    chk("fl_cnt", bus.fifo_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fl_quiet", bus.wb_vld, 0);
    end

    // 6. Reset mid-operation
    drv_alu(1'b1, 6'h21, 16'h8888);
    drv_ld(1'b1, 1'b1, 6'h22, 6'd5, 16'h0C01); tick();
    drv_ld(1'b1, 1'b1, 6'h23, 6'd5, 16'h0C02); tick();
    drv_ld(1'b1, 1'b1, 6'h24, 6'd5, 16'h0C03); tick();
    chk("rs_pre_cnt", bus.fifo_cnt, 3);
    chk("rs_pre_vld", bus.wb_vld, 1);
    rst = 1'b1;
    drv_ld(1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    #1 chk("rs_stll", bus.alu_stll, 0);
    tick();
    chk("rs_vld", bus.wb_vld, 0);
    chk("rs_data", bus.wb_data, 0);
    chk("rs_indx", bus.wb_indx, 0);
    chk("rs_phy", bus.wb_phy_addr, 0);
    chk("rs_rw", bus.wb_reg_wrt, 0);
    chk("rs_cnt", bus.fifo_cnt, 0);
    rst = 1'b0;
    drv_alu(1'b0, 6'd0, 16'h0);
    drv_ld(1'b1, 1'b1, 6'd9, 6'd3, 16'hCAFE);
    tick();
    drv_ld(1'b0, 1'b0, 6'd0, 6'd0, 16'h0);
    chk("rs_byp_vld", bus.wb_vld, 1);
    chk("rs_byp_data", bus.wb_data, 16'hCAFE);
    chk("rs_byp_indx", bus.wb_indx, 9);
    chk("rs_byp_cnt", bus.fifo_cnt, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_merge.md
Name: wb_merge

Overview:
- Writeback merge stage directly downstream of the load/store unit.
- Combines load results (vld_ld, indx_ld, phy_addr_ld, data_ld, reg_wrt_ld) and the ALU result port into the single register-file write / ROB completion port.
- The load unit cannot be back-pressured, so load results that lose arbitration are buffered in a small in-order FIFO.
- The ALU source is stalled when loads must drain.

Parameters:
- DEPTH, 4, load-result FIFO entries (power of two)
- STARVE_MAX, 3, maximum consecutive ALU wins while a load is pending
- DATA_W, 16, result data width
- IDX_W, 6, ROB index width
- PHY_W, 6, physical register address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flsh  in  1  pipeline flush (mispredict)
- vld_ld  in  1  load result valid (single-cycle pulse, no ready)
- reg_wrt_ld  in  1  load writes register file
- indx_ld  in  IDX_W  load ROB index
- phy_addr_ld  in  PHY_W  load destination physical register
- data_ld  in  DATA_W  load data
- alu_vld  in  1  ALU result valid
- alu_reg_wrt  in  1  ALU writes register file
- alu_indx  in  IDX_W  ALU ROB index
- alu_phy_addr  in  PHY_W  ALU destination physical register
- alu_data  in  DATA_W  ALU data
- alu_stll  out  1  ALU must hold its result this cycle (combinational)
- wb_vld  out  1  writeback valid (registered)
- wb_reg_wrt  out  1  register-file write enable qualifier
- wb_indx  out  IDX_W  ROB index completed
- wb_phy_addr  out  PHY_W  destination register
- wb_data  out  DATA_W  write data
- fifo_cnt  out  $clog2(DEPTH)+1  FIFO occupancy (debug/verification)

Behaviour:
- Reset: clk is the only clock and rst is synchronous and active-high. On rst, all outputs are 0, the FIFO is empty and starve_cnt is 0.
- Latency: the winning source appears on wb_* exactly one cycle after grant. All wb_* outputs are registered.
- Load pending (ld_pend): fifo_cnt != 0 or vld_ld.
- Load grant (ld_gnt): ld_pend and (!alu_vld, or starve_cnt == STARVE_MAX, or fifo_cnt >= DEPTH-1).
- ALU grant: alu_vld and !ld_gnt.
- alu_stll is alu_vld & ld_gnt. A stalled ALU holds all alu_* inputs stable. alu_stll is 0 during rst and flsh.
- Load source selection:
  - When ld_gnt and the FIFO is non-empty, the FIFO head is popped and written back. An incoming vld_ld in the same cycle is pushed to the tail (simultaneous push and pop).
  - When ld_gnt and the FIFO is empty, the incoming load bypasses straight to wb_* and is not pushed.
  - When a load is not granted, an incoming vld_ld is pushed.
- Ordering: loads are written back strictly in arrival order.
- Overflow guarantee: occupancy never exceeds DEPTH-1. Any push with fifo_cnt == DEPTH is an assertion failure.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when ld_pend and the ALU is granted.
  - Clears when a load is granted or when !ld_pend.
- Idle: with no grant, next wb_vld = 0 and the other wb_* hold their previous values.
- Load results with reg_wrt_ld=0 still occupy a writeback slot (ROB completion) and pass through with wb_reg_wrt=0.
- Flush (flsh=1), takes priority over everything except rst:
  - FIFO cleared and starve_cnt cleared.
  - Next-cycle wb_vld = 0.
  - vld_ld and alu_vld presented in the flush cycle are discarded.
- Simultaneous rst and flsh: reset behaviour.
- Width rules: no arithmetic on data. FIFO pointers are log2(DEPTH) bits wrapping modulo DEPTH. fifo_cnt is one bit wider.

Decomposition:
- Shared package: DATA_W, IDX_W, PHY_W constants and a wb_pkt typedef {reg_wrt, indx, phy_addr, data}, shared with the load queue and the register-file write port.
- One sub-module, wb_ld_fifo: a DEPTH-entry synchronous FIFO with push, pop, clr, head, cnt and same-cycle push+pop support.
- Arbitration and the output register live in wb_merge.

Test Plan:
1. Lone load: vld_ld=1, indx_ld=5, phy_addr_ld=12, data_ld=0xBEEF, reg_wrt_ld=1 at cycle t, ALU idle -> at t+1 wb_vld=1, wb_indx=5, wb_phy_addr=12, wb_data=0xBEEF, wb_reg_wrt=1; fifo_cnt stays 0.
2. Collision: at t, alu_vld with data 0x1111 and vld_ld with data 0x2222; ALU idle after t -> t+1 wb_data=0x1111 with fifo_cnt=1; t+2 wb_data=0x2222 with fifo_cnt=0; alu_stll=0 throughout.
3. Starvation: alu_vld held high for 8 cycles, one load at t -> ALU wins t..t+2; at t+3 ld_gnt and alu_stll=1; load appears on wb_* at t+4; the held ALU result completes at t+5.
4. Pressure: alu_vld held high, loads with data 0xA0..0xA5 on 6 consecutive cycles -> fifo_cnt never exceeds 3; all six loads are written back in order 0xA0..0xA5; no overflow assertion fires.
5. Flush: FIFO holds 2 entries, flsh=1 with vld_ld=1 and alu_vld=1 -> t+1 wb_vld=0, fifo_cnt=0, and none of the three results ever appears on wb_*.
6. Reset mid-operation: rst=1 while fifo_cnt=3 and wb_vld=1 -> next cycle all outputs 0 and fifo_cnt=0; a load the cycle after rst deasserts bypasses with 1-cycle latency.
